// File: rtl/pr_read_engine.sv
// Multi-channel AXI read front end: round-robin AR arbitration, rid-routed R beats, per-channel credited FIFOs.
// Optional build macro PR_RD_PRIO_EN gives channel NCH-1 strict priority over the round-robin.

module pr_rd_lane #(
    parameter int DATA_W    = 512,
    parameter int LOG_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              rsp_ready,
    output logic              can_take,
    output logic              cred_nz,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CW    = LOG_DEPTH + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]        count, cred;
    logic                 pop, do_push;

    assign rsp_valid = (count != '0);
    assign rsp_data  = mem[rd_ptr];
    assign pop       = rsp_valid & rsp_ready;
    // Credits keep this from ever seeing a push into a full FIFO; the guard only protects storage.
    assign do_push   = push & ((count != FULL) | pop);
    assign can_take  = (cred < FULL);
    assign cred_nz   = (cred != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cred   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(pop);
            case ({grant, pop})
                2'b10:   cred <= cred + 1'b1;
                2'b01:   cred <= cred - 1'b1;
                default: cred <= cred;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module pr_read_engine #(
    parameter int NCH       = 3,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 512,
    parameter int LOG_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ch_req_valid,
    input  logic [NCH*ADDR_W-1:0] ch_req_addr,
    output logic [NCH-1:0]        ch_req_ready,
    output logic [NCH-1:0]        ch_rsp_valid,
    output logic [NCH*DATA_W-1:0] ch_rsp_data,
    input  logic [NCH-1:0]        ch_rsp_ready,
    output logic [15:0]           arid_m,
    output logic [ADDR_W-1:0]     araddr_m,
    output logic [7:0]            arlen_m,
    output logic [2:0]            arsize_m,
    output logic                  arvalid_m,
    input  logic                  arready_m,
    input  logic [15:0]           rid_m,
    input  logic [DATA_W-1:0]     rdata_m,
    input  logic [1:0]            rresp_m,
    input  logic                  rlast_m,
    input  logic                  rvalid_m,
    output logic                  rready_m,
    output logic                  busy,
    output logic                  err
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [15:0]   NCH16 = 16'(NCH);
    localparam logic [PW-1:0] LAST  = PW'(NCH - 1);

    typedef struct packed {
        logic              vld;
        logic [15:0]       id;
        logic [ADDR_W-1:0] addr;
    } ar_slot_t;

    ar_slot_t                        ar;
    logic [PW-1:0]                   rr_ptr, gnt_idx;
    logic                            gnt_any, loadable;
    logic [NCH-1:0]                  eligible, can_take, cred_nz, beat_sel;
    logic [NCH-1:0][ADDR_W-1:0]      req_addr;
    logic [NCH-1:0][DATA_W-1:0]      rsp_data;
    logic                            rid_ok, err_set;
    logic [PW-1:0]                   rid_idx;
    logic                            unused_rlast;

    assign req_addr     = ch_req_addr;
    assign ch_rsp_data  = rsp_data;
    assign unused_rlast = rlast_m;

    assign arvalid_m = ar.vld;
    assign arid_m    = ar.id;
    assign araddr_m  = ar.addr;
    assign arlen_m   = 8'd0;
    assign arsize_m  = 3'b110;
    assign rready_m  = 1'b1;

    assign loadable = ~ar.vld | arready_m;
    assign rid_ok   = (rid_m < NCH16);
    assign rid_idx  = rid_m[PW-1:0];

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_any && eligible[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
`ifdef PR_RD_PRIO_EN
        if (eligible[NCH-1]) begin
            gnt_any = 1'b1;
            gnt_idx = LAST;
        end
`endif
        if (!loadable) gnt_any = 1'b0;
    end

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_lane
            assign eligible[i]     = ch_req_valid[i] & can_take[i];
            assign ch_req_ready[i] = gnt_any & (gnt_idx == PW'(i));
            assign beat_sel[i]     = rvalid_m & rid_ok & (rid_idx == PW'(i));

            pr_rd_lane #(.DATA_W(DATA_W), .LOG_DEPTH(LOG_DEPTH)) u_lane (
                .clk       (clk),
                .rst       (rst),
                .grant     (ch_req_ready[i]),
                .push      (beat_sel[i] & cred_nz[i]),
                .push_data (rdata_m),
                .rsp_ready (ch_rsp_ready[i]),
                .can_take  (can_take[i]),
                .cred_nz   (cred_nz[i]),
                .rsp_valid (ch_rsp_valid[i]),
                .rsp_data  (rsp_data[i])
            );
        end
    endgenerate

    // A beat with no outstanding credit can only be a leftover from before a reset.
    assign err_set = rvalid_m & ((rresp_m != 2'b00) | ~rid_ok | (|(beat_sel & ~cred_nz)));
    assign busy    = (|cred_nz) | ar.vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            ar     <= '0;
            rr_ptr <= '0;
            err    <= 1'b0;
        end else begin
            if (loadable) begin
                ar.vld <= gnt_any;
                if (gnt_any) begin
                    ar.id   <= 16'(gnt_idx);
                    ar.addr <= {req_addr[gnt_idx][ADDR_W-1:6], 6'b0};
`ifdef PR_RD_PRIO_EN
                    if (gnt_idx != LAST) rr_ptr <= gnt_idx + 1'b1;
`else
                    rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
`endif
                end
            end
            if (err_set) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pr_read_engine.sv
// Directed self-checking bench for pr_read_engine (NCH=3, LOG_DEPTH=2).
module tb_pr_read_engine;
    localparam int NCH = 3, AW = 64, DW = 512, LD = 2;

    logic              clk = 0, rst = 1;
    logic [NCH-1:0]    ch_req_valid = '0, ch_req_ready, ch_rsp_valid, ch_rsp_ready = '0;
    logic [NCH*AW-1:0] ch_req_addr = '0;
    logic [NCH*DW-1:0] ch_rsp_data;
    logic [15:0]       arid_m, rid_m = '0;
    logic [AW-1:0]     araddr_m;
    logic [7:0]        arlen_m;
    logic [2:0]        arsize_m;
    logic              arvalid_m, arready_m = 0, rlast_m = 1, rvalid_m = 0, rready_m, busy, err;
    logic [DW-1:0]     rdata_m = '0;
    logic [1:0]        rresp_m = '0;

    int n_checks = 0, n_fail = 0;

    logic [DW-1:0] dA = {16{32'hA0A0_0001}}, dB = {16{32'hB0B0_0002}}, dC = {16{32'hC0C0_0003}}, dD = {16{32'hD0D0_0004}};

    pr_read_engine #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .LOG_DEPTH(LD)) dut (
        .clk(clk), .rst(rst), .ch_req_valid(ch_req_valid), .ch_req_addr(ch_req_addr),
        .ch_req_ready(ch_req_ready), .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data),
        .ch_rsp_ready(ch_rsp_ready), .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m),
        .arsize_m(arsize_m), .arvalid_m(arvalid_m), .arready_m(arready_m), .rid_m(rid_m),
        .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m),
        .rready_m(rready_m), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1; ch_req_valid = '0; ch_rsp_ready = '0; arready_m = 0; rvalid_m = 0; rresp_m = '0; rid_m = '0;
        step(); step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (arvalid_m !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b exp 0", arvalid_m); end
        n_checks++; if (araddr_m !== '0) begin n_fail++; $display("FAIL reset_araddr got %h exp 0", araddr_m); end
        n_checks++; if (arid_m !== 16'd0) begin n_fail++; $display("FAIL reset_arid got %0d exp 0", arid_m); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_checks++; if (ch_rsp_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 000", ch_rsp_valid); end
        n_checks++; if (ch_req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_req_ready got %b exp 000", ch_req_ready); end
        n_checks++; if ({arlen_m, arsize_m, rready_m} !== {8'd0, 3'b110, 1'b1}) begin
            n_fail++; $display("FAIL const_outputs got len=%0d size=%b rready=%b exp 0/110/1", arlen_m, arsize_m, rready_m); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_addr [NCH];
        exp_addr[0] = 64'h1040; exp_addr[1] = 64'h2080; exp_addr[2] = 64'h30C0;
        do_reset();
        ch_req_addr[0*AW +: AW] = 64'h1047;
        ch_req_addr[1*AW +: AW] = 64'h2083;
        ch_req_addr[2*AW +: AW] = 64'h30FF;
        arready_m = 1; ch_req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++; if (ch_req_ready !== 3'(1 << (k % 3))) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", k, ch_req_ready, 3'(1 << (k % 3))); end
            step();
            n_checks++; if ({arvalid_m, arid_m} !== {1'b1, 16'(k % 3)}) begin n_fail++; $display("FAIL rr_arid[%0d] got v=%b id=%0d exp v=1 id=%0d", k, arvalid_m, arid_m, k % 3); end
            n_checks++; if (araddr_m !== exp_addr[k % 3]) begin n_fail++; $display("FAIL rr_araddr[%0d] got %h exp %h", k, araddr_m, exp_addr[k % 3]); end
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy got %b exp 1", busy); end
        ch_req_valid = '0;
    endtask

    task automatic test_credit();
        int grants;
        do_reset();
        arready_m = 1; ch_req_valid = 3'b001;
        grants = 0;
        for (int k = 0; k < 8; k++) begin #1; if (ch_req_ready[0]) grants++; step(); end
        n_checks++; if (grants !== 4) begin n_fail++; $display("FAIL credit_grants got %0d exp 4", grants); end
        rvalid_m = 1; rid_m = 16'd0; rdata_m = dD; #1;
        n_checks++; if (ch_req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL credit_stall got %b exp 0", ch_req_ready[0]); end
        step(); rvalid_m = 0;
        n_checks++; if ({ch_rsp_valid[0], ch_rsp_data[0 +: DW]} !== {1'b1, dD}) begin n_fail++; $display("FAIL credit_rsp got v=%b d=%h", ch_rsp_valid[0], ch_rsp_data[31:0]); end
        ch_rsp_ready = 3'b001; #1;
        n_checks++; if (ch_req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL credit_pop_cycle got %b exp 0", ch_req_ready[0]); end
        step(); ch_rsp_ready = '0;
        grants = 0;
        for (int k = 0; k < 6; k++) begin #1; if (ch_req_ready[0]) grants++; step(); end
        n_checks++; if (grants !== 1) begin n_fail++; $display("FAIL credit_regrant got %0d exp 1", grants); end
        ch_req_valid = '0;
    endtask

    task automatic test_stall();
        do_reset();
        arready_m = 0; ch_req_valid = 3'b010; #1;
        n_checks++; if (ch_req_ready !== 3'b010) begin n_fail++; $display("FAIL stall_first got %b exp 010", ch_req_ready); end
        step();
        ch_req_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (ch_req_ready !== 3'b000) begin n_fail++; $display("FAIL stall_nogrant[%0d] got %b exp 000", k, ch_req_ready); end
            n_checks++; if ({arvalid_m, arid_m, araddr_m, busy} !== {1'b1, 16'd1, 64'h2080, 1'b1}) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v=%b id=%0d a=%h b=%b exp 1/1/2080/1", k, arvalid_m, arid_m, araddr_m, busy); end
            step();
        end
        arready_m = 1; #1;
        n_checks++; if (ch_req_ready !== 3'b100) begin n_fail++; $display("FAIL stall_resume got %b exp 100", ch_req_ready); end
        step();
        n_checks++; if ({arid_m, araddr_m} !== {16'd2, 64'h30C0}) begin n_fail++; $display("FAIL stall_next got id=%0d a=%h exp 2/30c0", arid_m, araddr_m); end
        ch_req_valid = '0; step();
        n_checks++; if (arvalid_m !== 1'b0) begin n_fail++; $display("FAIL stall_drain got %b exp 0", arvalid_m); end
    endtask

    task automatic test_routing();
        do_reset();
        arready_m = 1; ch_req_valid = 3'b101;
        for (int k = 0; k < 4; k++) step();
        ch_req_valid = '0; step();
        rvalid_m = 1; rid_m = 16'd2; rdata_m = dA; step();
        rid_m = 16'd0; rdata_m = dB; step();
        rid_m = 16'd2; rdata_m = dC; step();
        rvalid_m = 0;
        n_checks++; if (ch_rsp_valid !== 3'b101) begin n_fail++; $display("FAIL route_valid got %b exp 101", ch_rsp_valid); end
        n_checks++; if (ch_rsp_data[2*DW +: DW] !== dA) begin n_fail++; $display("FAIL route_fifo2_first got %h exp %h", ch_rsp_data[2*DW +: 32], dA[31:0]); end
        n_checks++; if (ch_rsp_data[0 +: DW] !== dB) begin n_fail++; $display("FAIL route_fifo0 got %h exp %h", ch_rsp_data[31:0], dB[31:0]); end
        ch_rsp_ready = 3'b101; step(); ch_rsp_ready = '0;
        n_checks++; if ({ch_rsp_valid, ch_rsp_data[2*DW +: DW]} !== {3'b100, dC}) begin
            n_fail++; $display("FAIL route_fifo2_second got v=%b d=%h exp 100/%h", ch_rsp_valid, ch_rsp_data[2*DW +: 32], dC[31:0]); end
        ch_rsp_ready = 3'b100; step(); ch_rsp_ready = '0;
        n_checks++; if (ch_rsp_valid !== 3'b000) begin n_fail++; $display("FAIL route_empty got %b exp 000", ch_rsp_valid); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL route_err got %b exp 0", err); end
    endtask

    task automatic test_errors();
        do_reset();
        rvalid_m = 1; rid_m = 16'd7; rdata_m = dA; step(); rvalid_m = 0;
        n_checks++; if ({err, ch_rsp_valid} !== {1'b1, 3'b000}) begin n_fail++; $display("FAIL err_badid got err=%b v=%b exp 1/000", err, ch_rsp_valid); end
        step(); step(); step();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err); end
        do_reset();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
        rvalid_m = 1; rid_m = 16'd0; rdata_m = dB; step(); rvalid_m = 0;
        n_checks++; if ({err, ch_rsp_valid} !== {1'b1, 3'b000}) begin n_fail++; $display("FAIL err_stale got err=%b v=%b exp 1/000", err, ch_rsp_valid); end
        do_reset();
        arready_m = 1; ch_req_valid = 3'b010; step(); ch_req_valid = '0; step();
        rvalid_m = 1; rid_m = 16'd1; rresp_m = 2'b10; rdata_m = dC; step(); rvalid_m = 0; rresp_m = '0;
        n_checks++; if ({err, ch_rsp_valid, ch_rsp_data[1*DW +: DW]} !== {1'b1, 3'b010, dC}) begin
            n_fail++; $display("FAIL err_rresp got err=%b v=%b d=%h exp 1/010/%h", err, ch_rsp_valid, ch_rsp_data[1*DW +: 32], dC[31:0]); end
    endtask

`ifdef PR_RD_PRIO_EN
    task automatic test_priority();
        logic [2:0] exp_seq [8];
        exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b001, 3'b010};
        do_reset();
        arready_m = 1; ch_req_valid = 3'b111;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++; if (ch_req_ready !== exp_seq[k]) begin n_fail++; $display("FAIL prio[%0d] got %b exp %b", k, ch_req_ready, exp_seq[k]); end
            step();
        end
        ch_req_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_credit();
        test_stall();
        test_routing();
        test_errors();
`ifdef PR_RD_PRIO_EN
        test_priority();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
